gmii2fifo9: RTL and testbench
=============================

# gmii2fifo9

Receive-side companion to the 9-bit-FIFO-to-GMII transmitter. It samples a GMII receive stream on the PHY RX clock and writes each frame into the write port of a 9-bit asynchronous FIFO. Every frame byte is written with bit 8 set, and every frame is closed by one end-of-frame (EOF) status word with bit 8 clear. It sits between the PHY RX pins and the RX FIFO, and its output word format is the same one the transmit stage consumes.

## Interface
- MAX_FRAME, 1530: maximum bytes per frame, preamble and SFD included; bytes beyond this are truncated.
- LEN_WIDTH, 12: width of the internal byte-length counter; must satisfy 2^LEN_WIDTH > MAX_FRAME.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- gmii_rx_clk  in  1  PHY receive clock, 125 MHz; the only clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- gmii_rxd  in  8  receive data.
- din  out  9  FIFO write data: bit 8 = 1 for a frame byte, 0 for an EOF word.
- wr_en  out  1  FIFO write strobe.
- wr_clk  out  1  equals gmii_rx_clk, passed straight through.
- full  in  1  FIFO full flag, in the wr_clk domain.
- frame_ok_cnt  out  CNT_WIDTH  count of frames closed with EOF status 0.
- frame_err_cnt  out  CNT_WIDTH  count of frames closed with EOF status ≠ 0.
- frame_drop_cnt  out  CNT_WIDTH  count of frames dropped entirely (nothing written).

## Operation
- Input stage: dv, er and rxd are registered on every edge. All decisions below use the registered values (rdv, rer, rxd_q).
- EOF word format: din = {1'b0, 5'b0, oversize, overflow, rx_err}.
- State SYNC (entered at reset): wait until rdv=0, then go to IDLE. A frame already in progress when reset releases is never partially written and is not counted.
- IDLE, on rdv=1:
  - full=0: write {1,rxd_q}, set len=1, clear all status flags, go to FRAME.
  - full=1: no write, increment frame_drop_cnt, go to DISCARD_SILENT.
- FRAME, while rdv=1:
  - rer=1 sets rx_err; the byte is still written.
  - full=1: no write, set overflow, go to DISCARD.
  - len=MAX_FRAME: no write, set oversize, go to DISCARD.
  - otherwise: write {1,rxd_q}, increment len.
- FRAME, on rdv=0: go to EOF.
- DISCARD: ignore bytes (rer still sets rx_err); on rdv=0 go to EOF.
- DISCARD_SILENT: on rdv=0 go to IDLE. Nothing is written.
- EOF:
  - Write the EOF word on the first cycle with full=0.
  - Increment frame_ok_cnt if status=0, otherwise frame_err_cnt.
  - Next state is IDLE if rdv=0. If rdv=1 (a new frame began while waiting), go to DISCARD_SILENT and increment frame_drop_cnt.
  - While waiting with full=1, a rising rdv marks that frame as dropped; it is never partially written.
- Counters saturate at all-ones and never wrap.
- wr_en is never asserted while full=1 was sampled in the same cycle. There are no writes outside frame bytes and EOF words.

## Timing
- Reset (sys_rst_n=0): din=0, wr_en=0, all counters=0, state=SYNC, len=0, flags=0, input registers=0.
- Latency: a byte sampled on edge k is presented on din with wr_en=1 after edge k+1, and the FIFO captures it on edge k+2.
- din and wr_en are registered outputs; wr_en is high for exactly one cycle per word.
- full is sampled combinationally in the cycle the write decision is made, i.e. the cycle before wr_en is driven.
- Minimum gap: one rdv=0 cycle between frames is enough. The EOF write takes the first gap cycle when full=0.
- A counter increments in the same cycle its EOF word is written, or its drop is decided.
- Reset mid-frame clears everything immediately. Words already written stay in the FIFO; no EOF is emitted for them.

## Test plan
- Good frame: 8-byte preamble/SFD then 64 bytes with dv=1, er=0, full=0 -> 72 words with bit8=1 matching the input bytes in order, then {0,0x00}; frame_ok_cnt=1.
- Error mid-frame: 60-byte frame with er=1 on byte 20 -> 60 data words, then EOF {0,0x01}; frame_err_cnt=1.
- Overflow: full rises after 30 bytes of a 100-byte frame and falls 5 cycles after dv falls -> 30 data words, no writes while full=1, then EOF {0,0x02}; frame_err_cnt=1.
- Full at frame start, then full held through a 40-byte frame: no writes, frame_drop_cnt=1. The next frame, with full=0, is written normally.
- Oversize: 1600-byte frame with MAX_FRAME=1530 -> exactly 1530 data words, then EOF {0,0x04}.
- Reset: sys_rst_n released while dv=1 mid-frame -> no writes until dv falls. The next frame is written intact; all counters read 0 until that frame's EOF.

Source files
------------

// File: rtl/gmii2fifo9.sv
// gmii2fifo9: GMII receive stream to the write port of a 9-bit FIFO.
// Frame bytes are written with bit 8 set; each frame closes with an EOF status word, bit 8 clear.
module gmii2fifo9 #(
   parameter int unsigned MAX_FRAME = 1530,
   parameter int unsigned LEN_WIDTH = 12,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 gmii_rx_clk,
   input  logic                 sys_rst_n,
   input  logic                 gmii_rx_dv,
   input  logic                 gmii_rx_er,
   input  logic [7:0]           gmii_rxd,
   output logic [8:0]           din,
   output logic                 wr_en,
   output logic                 wr_clk,
   input  logic                 full,
   output logic [CNT_WIDTH-1:0] frame_ok_cnt,
   output logic [CNT_WIDTH-1:0] frame_err_cnt,
   output logic [CNT_WIDTH-1:0] frame_drop_cnt
);

   typedef enum logic [2:0] {
      StSync, StIdle, StFrame, StDiscard, StDiscardSilent, StEof
   } state_e;

   state_e               state_q, state_d;
   logic                 rdv, rer, in_valid;
   logic [7:0]           rxd_q;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic                 rx_err_q, rx_err_d, overflow_q, overflow_d;
   logic                 oversize_q, oversize_d, pend_drop_q, pend_drop_d;
   logic [8:0]           din_d;
   logic                 wr_en_d, ok_inc, err_inc, drop_inc;
   logic                 len_at_max;
   logic [2:0]           status;
   logic [8:0]           eof_word;

   assign wr_clk     = gmii_rx_clk;
   assign status     = {oversize_q, overflow_q, rx_err_q};
   assign eof_word   = {6'b0, status};
   assign len_at_max = (len_q == LEN_WIDTH'(MAX_FRAME));

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic inc);
      return (inc && (v != '1)) ? v + 1'b1 : v;
   endfunction

   // in_valid marks that rdv holds a real sample, so SYNC never trusts the reset value of rdv.
   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rdv      <= 1'b0;
         rer      <= 1'b0;
         rxd_q    <= 8'h00;
         in_valid <= 1'b0;
      end else begin
         rdv      <= gmii_rx_dv;
         rer      <= gmii_rx_er;
         rxd_q    <= gmii_rxd;
         in_valid <= 1'b1;
      end
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= StSync;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StSync:          if (in_valid && !rdv) state_d = StIdle;
         StIdle:          if (rdv) state_d = full ? StDiscardSilent : StFrame;
         StFrame: begin
            if (rdv) begin
               if (full || len_at_max) state_d = StDiscard;
            end else begin
               state_d = full ? StEof : StIdle;
            end
         end
         StDiscard:       if (!rdv) state_d = full ? StEof : StIdle;
         StDiscardSilent: if (!rdv) state_d = StIdle;
         StEof:           if (!full) state_d = rdv ? StDiscardSilent : StIdle;
         default:         state_d = StSync;
      endcase
   end

   always_comb begin
      din_d       = din;
      wr_en_d     = 1'b0;
      len_d       = len_q;
      rx_err_d    = rx_err_q;
      overflow_d  = overflow_q;
      oversize_d  = oversize_q;
      pend_drop_d = pend_drop_q;
      ok_inc      = 1'b0;
      err_inc     = 1'b0;
      drop_inc    = 1'b0;
      case (state_q)
         StIdle: begin
            if (rdv) begin
               if (!full) begin
                  wr_en_d     = 1'b1;
                  din_d       = {1'b1, rxd_q};
                  len_d       = LEN_WIDTH'(1);
                  rx_err_d    = rer;
                  overflow_d  = 1'b0;
                  oversize_d  = 1'b0;
                  pend_drop_d = 1'b0;
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end
         StFrame: begin
            if (rdv) begin
               if (rer) rx_err_d = 1'b1;
               if (full) begin
                  overflow_d = 1'b1;
               end else if (len_at_max) begin
                  oversize_d = 1'b1;
               end else begin
                  wr_en_d = 1'b1;
                  din_d   = {1'b1, rxd_q};
                  len_d   = len_q + 1'b1;
               end
            end else if (!full) begin
               wr_en_d = 1'b1;
               din_d   = eof_word;
               ok_inc  = (status == 3'b000);
               err_inc = (status != 3'b000);
            end
         end
         StDiscard: begin
            if (rdv) begin
               if (rer) rx_err_d = 1'b1;
            end else if (!full) begin
               wr_en_d = 1'b1;
               din_d   = eof_word;
               ok_inc  = (status == 3'b000);
               err_inc = (status != 3'b000);
            end
         end
         StEof: begin
            // A frame that starts while the EOF is stalled is dropped whole, counted once.
            if (!full) begin
               wr_en_d     = 1'b1;
               din_d       = eof_word;
               ok_inc      = (status == 3'b000);
               err_inc     = (status != 3'b000);
               drop_inc    = rdv || pend_drop_q;
               pend_drop_d = 1'b0;
            end else if (rdv) begin
               pend_drop_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         din            <= 9'h000;
         wr_en          <= 1'b0;
         len_q          <= '0;
         rx_err_q       <= 1'b0;
         overflow_q     <= 1'b0;
         oversize_q     <= 1'b0;
         pend_drop_q    <= 1'b0;
         frame_ok_cnt   <= '0;
         frame_err_cnt  <= '0;
         frame_drop_cnt <= '0;
      end else begin
         din            <= din_d;
         wr_en          <= wr_en_d;
         len_q          <= len_d;
         rx_err_q       <= rx_err_d;
         overflow_q     <= overflow_d;
         oversize_q     <= oversize_d;
         pend_drop_q    <= pend_drop_d;
         frame_ok_cnt   <= sat_inc(frame_ok_cnt, ok_inc);
         frame_err_cnt  <= sat_inc(frame_err_cnt, err_inc);
         frame_drop_cnt <= sat_inc(frame_drop_cnt, drop_inc);
      end
   end

endmodule

// File: tb/tb_gmii2fifo9.sv
// Directed bench for gmii2fifo9: table of frame scenarios plus hand-written reset sequences.
module tb_gmii2fifo9;

   logic        gmii_rx_clk = 1'b0;
   logic        sys_rst_n   = 1'b0;
   logic        gmii_rx_dv  = 1'b0;
   logic        gmii_rx_er  = 1'b0;
   logic [7:0]  gmii_rxd    = 8'h00;
   logic        full        = 1'b0;
   logic [8:0]  din;
   logic        wr_en, wr_clk;
   logic [15:0] frame_ok_cnt, frame_err_cnt, frame_drop_cnt;

   gmii2fifo9 dut (
      .gmii_rx_clk    (gmii_rx_clk),
      .sys_rst_n      (sys_rst_n),
      .gmii_rx_dv     (gmii_rx_dv),
      .gmii_rx_er     (gmii_rx_er),
      .gmii_rxd       (gmii_rxd),
      .din            (din),
      .wr_en          (wr_en),
      .wr_clk         (wr_clk),
      .full           (full),
      .frame_ok_cnt   (frame_ok_cnt),
      .frame_err_cnt  (frame_err_cnt),
      .frame_drop_cnt (frame_drop_cnt)
   );

   always #4 gmii_rx_clk = ~gmii_rx_clk;

   int passed = 0;
   int total  = 0;
   int viol   = 0;
   logic prev_full = 1'b0;
   logic [8:0] wq[$];

   // Words captured by the FIFO; wr_en must never follow a cycle in which full was high.
   always @(negedge gmii_rx_clk) begin
      if (wr_en) wq.push_back(din);
      if (wr_en && prev_full) viol++;
      prev_full = full;
   end

   typedef struct {
      string name;
      int n1, gap, n2, err_at, full_from, full_to;
      int exp1, eof1, exp2, eof2;
      int ok, err, drop;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   function automatic logic [7:0] byte_at(input int t);
      if (t < 7) return 8'h55;
      if (t == 7) return 8'hd5;
      return 8'((t * 13 + 7) & 255);
   endfunction

   task automatic drive(input logic dv, input logic er, input logic [7:0] d, input logic f);
      @(posedge gmii_rx_clk);
      #1;
      gmii_rx_dv = dv;
      gmii_rx_er = er;
      gmii_rxd   = d;
      full       = f;
   endtask

   task automatic compare_words(input string name, input logic [8:0] exp_q[$]);
      int bad = 0;
      check({name, "_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
         if (wq[i] !== exp_q[i]) begin
            if (bad == 0) $display("  %s first diff at %0d: got %h want %h", name, i, wq[i],
                                   exp_q[i]);
            bad++;
         end
      end
      check({name, "_data_diffs"}, bad, 0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [8:0] exp_q[$];
      int last, s2;
      logic in1, in2;
      wq.delete();
      s2   = v.n1 + v.gap;
      last = s2 + v.n2;
      if (v.full_to > last) last = v.full_to;
      last += 6;
      for (int t = 0; t < last; t++) begin
         in1 = (t < v.n1);
         in2 = (v.n2 > 0) && (t >= s2) && (t < s2 + v.n2);
         drive(in1 || in2, in1 && (t == v.err_at), byte_at(t),
               (t >= v.full_from) && (t < v.full_to));
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge gmii_rx_clk);
      #1;
      for (int i = 0; i < v.exp1; i++) exp_q.push_back({1'b1, byte_at(i)});
      if (v.eof1 >= 0) exp_q.push_back(9'(v.eof1));
      for (int i = 0; i < v.exp2; i++) exp_q.push_back({1'b1, byte_at(s2 + i)});
      if (v.eof2 >= 0) exp_q.push_back(9'(v.eof2));
      compare_words(v.name, exp_q);
      check({v.name, "_ok_cnt"}, frame_ok_cnt, v.ok);
      check({v.name, "_err_cnt"}, frame_err_cnt, v.err);
      check({v.name, "_drop_cnt"}, frame_drop_cnt, v.drop);
   endtask

   initial begin
      logic [8:0] exp_q[$];
      //            name        n1   gap n2  err  ffrom fto  exp1 eof1 exp2 eof2 ok err drop
      vecs[0] = '{"good",      72,   0,  0, -1,  -1,  -1,   72,  0,   0, -1,  1, 0, 0};
      vecs[1] = '{"rx_err",    60,   0,  0, 20,  -1,  -1,   60,  1,   0, -1,  1, 1, 0};
      vecs[2] = '{"overflow",  100,  0,  0, -1,  31, 105,   30,  2,   0, -1,  1, 2, 0};
      vecs[3] = '{"drop_start", 40,  4, 50, -1,   0,  42,    0, -1,  50,  0,  2, 2, 1};
      vecs[4] = '{"min_gap",    20,  1, 20, -1,  -1,  -1,   20,  0,  20,  0,  4, 2, 1};
      vecs[5] = '{"eof_stall",  10,  1, 10, -1,  11,  14,   10,  0,   0, -1,  5, 2, 2};
      vecs[6] = '{"oversize", 1600,  0,  0, -1,  -1,  -1, 1530,  4,   0, -1,  5, 3, 2};

      repeat (3) @(posedge gmii_rx_clk);
      #1;
      check("rst_din", din, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_ok_cnt", frame_ok_cnt, 0);
      check("rst_err_cnt", frame_err_cnt, 0);
      check("rst_drop_cnt", frame_drop_cnt, 0);
      sys_rst_n = 1'b1;
      repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge gmii_rx_clk);
      #1;
      check("wr_clk_follows", wr_clk, gmii_rx_clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset asserted and released mid-frame, while dv stays high.
      for (int t = 0; t < 6; t++) drive(1'b1, 1'b0, byte_at(t), 1'b0);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_ok_cnt", frame_ok_cnt, 0);
      check("midrst_err_cnt", frame_err_cnt, 0);
      check("midrst_drop_cnt", frame_drop_cnt, 0);
      check("midrst_wr_en", wr_en, 0);
      drive(1'b1, 1'b0, 8'h11, 1'b0);
      drive(1'b1, 1'b0, 8'h22, 1'b0);
      wq.delete();
      sys_rst_n = 1'b1;
      for (int t = 0; t < 12; t++) drive(1'b1, 1'b0, byte_at(t + 30), 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check("midrst_no_writes", wq.size(), 0);
      for (int t = 0; t < 30; t++) drive(1'b1, 1'b0, byte_at(t + 100), 1'b0);
      @(negedge gmii_rx_clk);
      check("midrst_cnt_before_eof", frame_ok_cnt, 0);
      repeat (5) drive(1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge gmii_rx_clk);
      #1;
      for (int i = 0; i < 30; i++) exp_q.push_back({1'b1, byte_at(i + 100)});
      exp_q.push_back(9'h000);
      compare_words("midrst_frame", exp_q);
      check("midrst_ok_after", frame_ok_cnt, 1);
      check("midrst_err_after", frame_err_cnt, 0);
      check("midrst_drop_after", frame_drop_cnt, 0);

      check("no_wr_while_full", viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
